// File: rtl/instruction_controller_if.sv
// Control/status bundle between the instruction controller and the rest of
// the processor: instruction ROM port, user Enter switch, datapath flags and
// the control word driven into the A-register datapath.
interface instruction_controller_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [7:0]            Instr;
  logic                  Enter;
  logic                  Aeq0;
  logic                  Apos;
  logic [ADDR_WIDTH-1:0] PCaddr;
  logic [1:0]            Asel;
  logic                  Aload;
  logic                  Sub;
  logic                  OutStrobe;
  logic                  Halted;

  // Controller side: consumes ROM data, Enter and flags; drives controls.
  modport master (
    input  Instr, Enter, Aeq0, Apos,
    output PCaddr, Asel, Aload, Sub, OutStrobe, Halted
  );

  // Datapath / ROM / environment side.
  modport slave (
    output Instr, Enter, Aeq0, Apos,
    input  PCaddr, Asel, Aload, Sub, OutStrobe, Halted
  );
endinterface

// File: rtl/instruction_controller.sv
// Instruction controller for the 8-bit A-register datapath.
// Three-cycle FETCH/DECODE/EXECUTE loop against a 1-cycle synchronous ROM,
// plus an IN handshake (WAIT_IN/WAIT_REL) and a sticky HALT state.
module instruction_controller #(
  parameter int ADDR_WIDTH  = 5,
  parameter int ROM_LATENCY = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  instruction_controller_if.master bus
);

  // The FETCH->DECODE spacing only works for a single-cycle ROM, and the
  // address field of an instruction is only five bits wide.
  if (ROM_LATENCY != 1) begin : g_lat_chk
    $error("instruction_controller: ROM_LATENCY must be 1");
  end
  if (ADDR_WIDTH > 5 || ADDR_WIDTH < 1) begin : g_aw_chk
    $error("instruction_controller: ADDR_WIDTH must be 1..5");
  end

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, WAIT_IN, WAIT_REL, HALT
  } state_t;

  localparam logic [2:0] OP_IN   = 3'b000;
  localparam logic [2:0] OP_OUT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LDQ  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_JPOS = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ASEL_IN  = 2'b00;
  localparam logic [1:0] ASEL_ALU = 2'b01;
  localparam logic [1:0] ASEL_Q   = 2'b10;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [7:0]            ir, ir_nxt;
  logic [2:0]            op;
  logic [ADDR_WIDTH-1:0] target;

  assign op         = ir[7:5];
  assign target     = ir[ADDR_WIDTH-1:0];
  assign bus.PCaddr = pc;

  // State, PC and IR registers; reset aborts any in-flight instruction.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state, PC/IR update and control-word decode from state and IR.
  // Controls are decoded only from registers, except the WAIT_IN load which
  // must follow the Enter level so a press already held on entry loads on
  // the very first WAIT_IN cycle.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    bus.Asel      = ASEL_IN;
    bus.Aload     = 1'b0;
    bus.Sub       = 1'b0;
    bus.OutStrobe = 1'b0;
    bus.Halted    = 1'b0;

    case (state)
      FETCH: begin
        // ROM samples PCaddr=pc at the end of this cycle; wraps naturally.
        pc_nxt    = pc + ADDR_WIDTH'(1);
        state_nxt = DECODE;
      end

      DECODE: begin
        // ROM word for the address presented in FETCH is valid now.
        ir_nxt    = bus.Instr;
        state_nxt = EXECUTE;
      end

      EXECUTE: begin
        state_nxt = FETCH;
        case (op)
          OP_IN:   state_nxt = WAIT_IN;
          OP_OUT:  bus.OutStrobe = 1'b1;
          OP_ADD: begin
            bus.Asel  = ASEL_ALU;
            bus.Aload = 1'b1;
          end
          OP_SUB: begin
            bus.Asel  = ASEL_ALU;
            bus.Sub   = 1'b1;
            bus.Aload = 1'b1;
          end
          OP_LDQ: begin
            bus.Asel  = ASEL_Q;
            bus.Aload = 1'b1;
          end
          // Flags reflect A after the previous instruction's load; a taken
          // branch overrides the increment already done in FETCH.
          OP_JZ:   if (bus.Aeq0) pc_nxt = target;
          OP_JPOS: if (bus.Apos) pc_nxt = target;
          OP_HALT: state_nxt = HALT;
          default: state_nxt = FETCH;
        endcase
      end

      WAIT_IN: begin
        if (bus.Enter) begin
          bus.Asel  = ASEL_IN;
          bus.Aload = 1'b1;
          state_nxt = WAIT_REL;
        end
      end

      // Wait for the switch to drop so one press cannot feed two INs.
      WAIT_REL: begin
        if (!bus.Enter) state_nxt = FETCH;
      end

      HALT: begin
        bus.Halted = 1'b1;
      end

      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instruction_controller.sv
// Directed bench for instruction_controller: synchronous 1-cycle ROM model,
// datapath flags and Enter driven directly, cycle-exact expected values.
module tb_instruction_controller;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  instruction_controller_if #(.ADDR_WIDTH(5)) bus ();

  instruction_controller #(.ADDR_WIDTH(5), .ROM_LATENCY(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 Clock = ~Clock;

  logic [7:0] rom [32];

  // Synchronous ROM, one cycle from PCaddr to Instr.
  always @(posedge Clock) bus.Instr <= rom[bus.PCaddr];

  int n_chk  = 0;
  int n_fail = 0;
  int cnt, cnt2, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) rom[i] = v;
  endtask

  // Leaves the bench #1 after an edge, in the first FETCH cycle (cycle 0).
  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    bus.Enter = 1'b0;
    bus.Aeq0  = 1'b0;
    bus.Apos  = 1'b0;
    fill(8'hE0);

    // ---- reset abort mid-SUB ----
    rom[0] = 8'h60;  // SUB
    do_reset();
    chk("rst_pcaddr", 32'(bus.PCaddr), 0);
    chk("rst_outs", {bus.Asel, bus.Aload, bus.Sub, bus.OutStrobe, bus.Halted}, 0);
    step(); step();  // cycle 2: EXECUTE SUB
    chk("sub_aload", 32'(bus.Aload), 1);
    chk("sub_asel_sub", {bus.Asel, bus.Sub}, 3'b011);
    Reset = 1'b0;
    #1;
    chk("abort_aload", 32'(bus.Aload), 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    chk("rel_pcaddr", 32'(bus.PCaddr), 0);
    chk("rel_outs", {bus.Asel, bus.Aload, bus.Sub, bus.OutStrobe, bus.Halted}, 0);
    step();
    chk("rel_decode_noload", 32'(bus.Aload), 0);
    step();
    chk("rel_exec_load", 32'(bus.Aload), 1);

    // ---- IN / OUT / HALT ----
    fill(8'hE0);
    rom[0] = 8'h00; rom[1] = 8'h20; rom[2] = 8'hE0;
    do_reset();
    step(); step(); step();              // cycle 3
    cnt = 0;
    repeat (3) begin cnt += int'(bus.Aload); step(); end   // cycles 3..5
    chk("in_wait_noload", cnt, 0);
    bus.Enter = 1'b1; #1;               // cycle 6
    chk("in_aload", 32'(bus.Aload), 1);
    chk("in_asel", 32'(bus.Asel), 0);
    cnt = 0; cnt2 = 0;
    step();                              // cycle 7
    repeat (3) begin cnt += int'(bus.Aload); cnt2 += int'(bus.OutStrobe); step(); end
    bus.Enter = 1'b0; #1;                // cycle 10
    cnt += int'(bus.Aload); cnt2 += int'(bus.OutStrobe);
    chk("in_single_load", cnt, 0);
    chk("out_not_early", cnt2, 0);
    step();                              // cycle 11: FETCH of OUT
    chk("out_fetch_pc", 32'(bus.PCaddr), 1);
    step(); step();                      // cycle 13
    chk("out_strobe", 32'(bus.OutStrobe), 1);
    step();
    chk("out_strobe_pulse", 32'(bus.OutStrobe), 0);
    step(); step(); step();              // cycle 17
    chk("halted", 32'(bus.Halted), 1);
    chk("halt_pc", 32'(bus.PCaddr), 3);
    repeat (4) step();
    chk("halt_pc_frozen", 32'(bus.PCaddr), 3);
    chk("halt_outs", {bus.Asel, bus.Aload, bus.Sub, bus.OutStrobe, bus.Halted}, 1);

    // ---- LDQ / SUB / JZ taken ----
    fill(8'hE0);
    rom[0] = 8'h80; rom[1] = 8'h60; rom[2] = 8'hA5; rom[5] = 8'hE0;
    bus.Aeq0 = 1'b1;
    do_reset();
    step(); step();                      // cycle 2
    chk("ldq_ctl", {bus.Asel, bus.Aload, bus.Sub}, 4'b1010);
    step(); step(); step();              // cycle 5
    chk("sub_ctl", {bus.Asel, bus.Aload, bus.Sub}, 4'b0111);
    step(); step(); step();              // cycle 8
    chk("jz_no_aload", 32'(bus.Aload), 0);
    step();                              // cycle 9
    chk("jz_taken_pc", 32'(bus.PCaddr), 5);
    step(); step(); step();              // cycle 12
    chk("jz_halted", {bus.Halted, bus.PCaddr}, {1'b1, 5'd6});

    // ---- JZ not taken ----
    bus.Aeq0 = 1'b0;
    do_reset();
    repeat (9) step();
    chk("jz_not_taken_pc", 32'(bus.PCaddr), 3);
    step(); step(); step();
    chk("jz_nt_halted", {bus.Halted, bus.PCaddr}, {1'b1, 5'd4});

    // ---- JPOS tight self-loop ----
    fill(8'hE0);
    rom[0] = 8'hC0;
    bus.Apos = 1'b1;
    do_reset();
    repeat (3) step();
    chk("jpos_self1", 32'(bus.PCaddr), 0);
    repeat (3) step();
    chk("jpos_self2", 32'(bus.PCaddr), 0);
    bus.Apos = 1'b0;
    repeat (3) step();
    chk("jpos_not_taken", 32'(bus.PCaddr), 1);

    // ---- IN, IN with one Enter press ----
    fill(8'hE0);
    rom[0] = 8'h00; rom[1] = 8'h00;
    do_reset();
    step(); step(); step();              // cycle 3: WAIT_IN
    bus.Enter = 1'b1; #1;
    chk("inin_first", 32'(bus.Aload), 1);
    cnt = 0;
    for (int c = 4; c <= 14; c++) begin
      step();
      if (c == 8) begin bus.Enter = 1'b0; #1; end
      cnt += int'(bus.Aload);
    end
    chk("inin_no_second", cnt, 0);
    chk("inin_waiting_pc", 32'(bus.PCaddr), 2);
    step();                              // cycle 15
    bus.Enter = 1'b1; #1;
    chk("inin_second", {bus.Aload, bus.Asel}, 3'b100);
    step();
    chk("inin_second_pulse", 32'(bus.Aload), 0);
    bus.Enter = 1'b0;

    // ---- Enter already high on entry to WAIT_IN ----
    fill(8'hE0);
    rom[0] = 8'h00;
    bus.Enter = 1'b1;
    do_reset();
    step(); step();
    chk("entry_exec_noload", 32'(bus.Aload), 0);
    step();
    chk("entry_first_load", 32'(bus.Aload), 1);
    step();
    chk("entry_one_pulse", 32'(bus.Aload), 0);
    bus.Enter = 1'b0;

    // ---- PC wrap with ADD everywhere ----
    fill(8'h40);
    do_reset();
    bad = 0;
    for (int c = 0; c < 99; c++) begin
      if (bus.Aload !== (c % 3 == 2)) bad++;
      if ((c % 3 == 2) && (bus.Asel !== 2'b01 || bus.Sub !== 1'b0)) bad++;
      if ((c % 3 == 0) && (bus.PCaddr !== 5'((c / 3) % 32))) bad++;
      if (c == 93) chk("wrap_pc31", 32'(bus.PCaddr), 31);
      if (c == 96) chk("wrap_pc0", 32'(bus.PCaddr), 0);
      step();
    end
    chk("wrap_pattern", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
